// File: rtl/mips_pkg.sv
// Shared definitions for the program loader.
//
// Contents:
//   loader_state_t - encoding of the loader FSM states
//   HDR_BYTES      - number of bytes in the frame header (the word count N)
//   COUNT_W        - width of the word count carried by the header
package mips_pkg;

    // Frame header is a big-endian 16-bit word count.
    localparam int HDR_BYTES = 2;
    localparam int COUNT_W   = 8 * HDR_BYTES;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,  // waiting for count high byte
        HDR_LO = 3'd1,  // waiting for count low byte
        DATA   = 3'd2,  // collecting payload bytes into a word
        WRITE  = 3'd3,  // one-cycle instruction-memory write
        CSUM   = 3'd4,  // waiting for the checksum byte
        DONE   = 3'd5,  // program loaded, CPU released
        ERR    = 3'd6   // bad length or bad checksum, CPU held
    } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream and writes it into
// instruction memory, holding the CPU in reset until a frame with a good
// checksum has been fully written.
//
// Frame: count N (16 bit, high byte first), 4*N payload bytes (each word
// big-endian), then a checksum byte equal to the XOR of all bytes before it.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - asynchronous reset, active low
//   rx_valid   - upstream byte valid
//   rx_data    - upstream byte
//   rx_ready   - loader can accept a byte
//   reload     - single-cycle request to restart from DONE or ERR
//   imem_we    - instruction-memory write strobe
//   imem_addr  - instruction-memory byte address (word aligned)
//   imem_wdata - instruction word to write
//   cpu_rst    - active-high hold to the CPU, low only in DONE
//   done       - frame loaded successfully
//   error      - frame rejected (length or checksum)
//   state_dbg  - current FSM state encoding, for observation only
//
// Handshake: a byte transfers at a rising edge where rx_valid and rx_ready
// are both high. rx_ready never depends on rx_valid; upstream must hold
// rx_valid and rx_data stable until the transfer happens.
module prog_loader
    import mips_pkg::*;
#(
    parameter int IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_dbg
);

    localparam logic [COUNT_W:0] MAX_WORDS = (COUNT_W+1)'(IMEM_WORDS);

    loader_state_t      state;
    loader_state_t      state_next;

    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] word_index;
    logic [1:0]         byte_cnt;
    logic [31:0]        asm_word;
    logic [7:0]         checksum;

    logic               xfer;
    logic [COUNT_W-1:0] header_n;
    logic               last_word;

    assign xfer      = rx_valid && rx_ready;
    // Full count as it becomes known on the low header byte.
    assign header_n  = {count[COUNT_W-1:8], rx_data};
    assign last_word = (word_index == count - 1'b1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HDR_HI;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            HDR_HI: begin
                if (xfer) state_next = HDR_LO;
            end
            HDR_LO: begin
                if (xfer) begin
                    if (header_n == '0)
                        state_next = CSUM;
                    else if ({1'b0, header_n} > MAX_WORDS)
                        state_next = ERR;
                    else
                        state_next = DATA;
                end
            end
            DATA: begin
                // Fourth byte of a word completes it.
                if (xfer && byte_cnt == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                state_next = last_word ? CSUM : DATA;
            end
            CSUM: begin
                if (xfer) state_next = (rx_data == checksum) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (reload) state_next = HDR_HI;
            end
            default: state_next = HDR_HI;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from state; addr/data forced to zero outside WRITE)
    // ------------------------------------------------------------------
    always_comb begin
        rx_ready   = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state)
            HDR_HI, HDR_LO, DATA, CSUM: rx_ready = rst;
            WRITE: begin
                imem_we    = 1'b1;
                imem_addr  = {{(30-COUNT_W){1'b0}}, word_index, 2'b00};
                imem_wdata = asm_word;
            end
            DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            ERR: begin
                error = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Datapath: header count, word assembly, checksum, word index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            word_index <= '0;
            byte_cnt   <= '0;
            asm_word   <= '0;
            checksum   <= '0;
        end else begin
            unique case (state)
                HDR_HI: begin
                    if (xfer) begin
                        count[COUNT_W-1:8] <= rx_data;
                        checksum           <= checksum ^ rx_data;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        count[7:0] <= rx_data;
                        checksum   <= checksum ^ rx_data;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        asm_word <= {asm_word[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        checksum <= checksum ^ rx_data;
                    end
                end
                WRITE: begin
                    word_index <= word_index + 1'b1;
                end
                DONE, ERR: begin
                    if (reload) begin
                        count      <= '0;
                        word_index <= '0;
                        byte_cnt   <= '0;
                        asm_word   <= '0;
                        checksum   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam logic [2:0] S_HDR_HI = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [2:0]  state_dbg;

    int checks;
    int errors;
    int ready_in_write;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    prog_loader #(.IMEM_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- write monitor ----------------
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_q.push_back({imem_addr, imem_wdata});
            if (rx_ready !== 1'b0) ready_in_write++;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the byte transfers.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout byte=%02h rx_ready=%b required 1", b, rx_ready);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({rx_ready, cpu_rst, done, error, imem_we} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_flags got rdy/cpu/done/err/we=%b required 01000",
                     {rx_ready, cpu_rst, done, error, imem_we});
        end
        checks++;
        if (imem_addr !== 32'h0 || imem_wdata !== 32'h0 || state_dbg !== S_HDR_HI) begin
            errors++;
            $display("FAIL reset_bus got addr=%h wdata=%h state=%0d required 0 0 0",
                     imem_addr, imem_wdata, state_dbg);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b required 1", rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_single_word();
        exp_q.delete();
        got_q.delete();
        exp_q.push_back({32'h0000_0000, 32'h2008_0005});
        send_frame('{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C});
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL single_write got n=%0d first=%h required n=1 %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'h0, exp_q[0]);
        end
        checks++;
        if ({done, error, cpu_rst} !== 3'b100) begin
            errors++;
            $display("FAIL single_status got done/err/cpu=%b required 100", {done, error, cpu_rst});
        end
        // DONE ignores incoming bytes.
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0 || state_dbg !== S_DONE) begin
            errors++;
            $display("FAIL done_hold got rdy=%b state=%0d required 0 %0d", rx_ready, state_dbg, S_DONE);
        end
        rx_valid = 1'b0;
        pulse_reload();
        checks++;
        if (state_dbg !== S_HDR_HI || {done, cpu_rst} !== 2'b01) begin
            errors++;
            $display("FAIL reload_from_done got state=%0d done/cpu=%b required 0 01",
                     state_dbg, {done, cpu_rst});
        end
    endtask

    task automatic test_empty_frame();
        got_q.delete();
        send_byte(8'h00);
        rx_valid = 1'b0;
        // Reload outside DONE/ERR must be ignored.
        pulse_reload();
        checks++;
        if (state_dbg !== S_HDR_LO) begin
            errors++;
            $display("FAIL reload_ignored got state=%0d required %0d", state_dbg, S_HDR_LO);
        end
        send_frame('{8'h00, 8'h00});
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL empty_no_write got writes=%0d required 0", got_q.size());
        end
        checks++;
        if ({done, error, cpu_rst} !== 3'b100) begin
            errors++;
            $display("FAIL empty_status got done/err/cpu=%b required 100", {done, error, cpu_rst});
        end
        pulse_reload();
    endtask

    task automatic test_bad_checksum();
        got_q.delete();
        send_frame('{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D});
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {32'h0, 32'h2008_0005}) begin
            errors++;
            $display("FAIL badcs_write got n=%0d required 1 write of 20080005", got_q.size());
        end
        checks++;
        if ({done, error, cpu_rst, rx_ready} !== 4'b0110) begin
            errors++;
            $display("FAIL badcs_status got done/err/cpu/rdy=%b required 0110",
                     {done, error, cpu_rst, rx_ready});
        end
        pulse_reload();
        checks++;
        if (state_dbg !== S_HDR_HI || error !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_from_err got state=%0d err=%b rdy=%b required 0 0 1",
                     state_dbg, error, rx_ready);
        end
    endtask

    task automatic test_oversize();
        got_q.delete();
        send_frame('{8'h01, 8'h01});
        checks++;
        if (state_dbg !== S_ERR || error !== 1'b1 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL oversize got state=%0d err=%b cpu=%b required %0d 1 1",
                     state_dbg, error, cpu_rst, S_ERR);
        end
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL oversize_no_write got writes=%0d required 0", got_q.size());
        end
        pulse_reload();
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        exp_q.delete();
        ready_in_write = 0;
        exp_q.push_back({32'h0000_0000, 32'h1122_3344});
        exp_q.push_back({32'h0000_0004, 32'h5566_7788});
        // Checksum: 02 ^ (11^22^33^44) ^ (55^66^77^88) = 02 ^ 44 ^ CC = 8A
        send_frame('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                     8'h55, 8'h66, 8'h77, 8'h88, 8'h8A});
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_write%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (ready_in_write != 0) begin
            errors++;
            $display("FAIL b2b_ready_in_write got %0d cycles required 0", ready_in_write);
        end
        checks++;
        if ({done, error, cpu_rst} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_status got done/err/cpu=%b required 100", {done, error, cpu_rst});
        end
        pulse_reload();
    endtask

    task automatic test_reset_mid_frame();
        got_q.delete();
        send_frame('{8'h00, 8'h01, 8'h20, 8'h08, 8'h00});
        rst = 1'b0;
        #1;
        checks++;
        if (state_dbg !== S_HDR_HI || rx_ready !== 1'b0 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async got state=%0d rdy=%b cpu=%b required 0 0 1",
                     state_dbg, rx_ready, cpu_rst);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_no_write got writes=%0d required 0", got_q.size());
        end
        send_frame('{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C});
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {32'h0, 32'h2008_0005} || done !== 1'b1) begin
            errors++;
            $display("FAIL midrst_reload got n=%0d done=%b required 1 write, done 1",
                     got_q.size(), done);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks         = 0;
        errors         = 0;
        ready_in_write = 0;
        rst            = 1'b0;
        rx_valid       = 1'b0;
        rx_data        = 8'h00;
        reload         = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_empty_frame();
        test_bad_checksum();
        test_oversize();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 256, meaning instruction-memory capacity in 32-bit words (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 SHALL have port rx_valid  input  1  upstream byte-stream valid.
REQ-005 SHALL have port rx_data  input  8  upstream byte.
REQ-006 SHALL have port rx_ready  output  1  loader accepts a byte; transfer when rx_valid and rx_ready are both high at a rising edge.
REQ-007 SHALL have port reload  input  1  single-cycle request to restart loading from DONE or ERR.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-009 SHALL have port imem_addr  output  32  instruction-memory byte address (word-aligned).
REQ-010 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port cpu_rst  output  1  active-high hold driven to the CPU reset; high while not loaded.
REQ-012 SHALL have ports done and error, each output 1, status flags.

Function
REQ-013 Frame format SHALL be: count N (16-bit, high byte first), then 4*N payload bytes (each word big-endian, first byte = bits 31:24), then one checksum byte.
REQ-014 Checksum SHALL be the XOR of every byte preceding it in the frame (both count bytes and all payload bytes).
REQ-015 States SHALL be HDR_HI, HDR_LO, DATA, WRITE, CSUM, DONE, ERR.
REQ-016 rx_ready SHALL be 1 exactly in HDR_HI, HDR_LO, DATA, CSUM while rst is deasserted; 0 otherwise.
REQ-017 HDR_HI -> HDR_LO on a transfer; HDR_LO -> DATA on a transfer if 1 <= N <= IMEM_WORDS, -> CSUM if N = 0, -> ERR if N > IMEM_WORDS.
REQ-018 In DATA, every 4th accepted byte SHALL move to WRITE; bytes shift into a 32-bit assembly register.
REQ-019 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr = word_index*4, imem_wdata = assembled word; next state DATA, or CSUM if word_index = N-1.
REQ-020 word_index SHALL start at 0 per frame and increment after each WRITE; imem_we SHALL be 0 in every other state.
REQ-021 In CSUM, an accepted byte equal to the running XOR SHALL move to DONE, otherwise to ERR.
REQ-022 DONE: cpu_rst=0, done=1, error=0; ERR: cpu_rst=1, done=0, error=1; both hold indefinitely, ignoring rx_valid.
REQ-023 reload=1 in DONE or ERR SHALL move to HDR_HI next cycle, setting cpu_rst=1, clearing done, error, checksum and word_index; reload SHALL be ignored in other states.
REQ-024 cpu_rst SHALL be 1 in every state except DONE.
REQ-025 A byte presented during WRITE SHALL not be consumed; upstream must hold it (rx_valid/rx_data stable until transfer).

Reset
REQ-026 While rst=0, independently of clk: state=HDR_HI, cpu_rst=1, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, rx_ready=0, checksum=0, word_index=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; no partial write occurs, and loading restarts at HDR_HI after release.

Structure
REQ-028 State encoding and the frame-header length constant SHALL reside in the shared package mips_pkg.
REQ-029 No sub-module is required; byte assembly, checksum and FSM SHALL be implemented within prog_loader.

Verification
REQ-030 Frame 00 01 20 08 00 05 2C -> one write: addr 0x00000000, data 0x20080005; then done=1, cpu_rst=0.
REQ-031 Frame 00 00 00 -> no imem_we pulse; done=1.
REQ-032 Frame 00 01 20 08 00 05 2D -> write still occurs; then error=1, cpu_rst=1; reload pulse -> HDR_HI, error=0.
REQ-033 IMEM_WORDS=256, header 01 01 -> ERR after second byte, no writes.
REQ-034 rx_valid held continuously through a two-word frame -> rx_ready=0 during each WRITE cycle, no byte lost or duplicated, addresses 0x0 and 0x4.
REQ-035 rst pulled low after 3 payload bytes -> imem_we never pulses; a subsequent valid frame loads correctly.
